// File: rtl/oled_cmd_rx_pkg.sv
//------------------------------------------------------------------------------
// oled_cmd_rx_pkg : opcodes, register reset values and FSM states for oled_cmd_rx
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package oled_cmd_rx_pkg;

  localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
  localparam logic [7:0] CMD_SEG_NORM    = 8'hA0;
  localparam logic [7:0] CMD_SEG_REMAP   = 8'hA1;
  localparam logic [7:0] CMD_COM_NORM    = 8'hC0;
  localparam logic [7:0] CMD_COM_REMAP   = 8'hC8;
  localparam logic [7:0] CMD_CONTRAST    = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
  localparam logic [7:0] CMD_COM_CFG     = 8'hDA;
  localparam logic [7:0] CMD_ADDR_MODE   = 8'h20;

  localparam logic [7:0] RST_CONTRAST  = 8'h7F;
  localparam logic [7:0] RST_PRECHARGE = 8'h22;
  localparam logic [7:0] RST_COM_CFG   = 8'h12;
  localparam logic [1:0] RST_ADDR_MODE = 2'b10;

  typedef enum logic [0:0] {
    RxIdle  = 1'b0,
    RxParam = 1'b1
  } rx_state_t;

  function automatic logic takes_param(input logic [7:0] op);
    return (op == CMD_CONTRAST) || (op == CMD_CHARGE_PUMP) || (op == CMD_PRECHARGE) ||
           (op == CMD_COM_CFG) || (op == CMD_ADDR_MODE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/oled_cmd_rx_if.sv
//------------------------------------------------------------------------------
// oled_cmd_rx_if : SPI input lines and decoded shadow-register outputs
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface oled_cmd_rx_if;
  logic       cs;
  logic       sclk;
  logic       sdo;
  logic       dc;
  logic       res;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_data;
  logic       disp_on;
  logic       charge_pump;
  logic [7:0] contrast;
  logic [7:0] precharge;
  logic [7:0] com_cfg;
  logic [1:0] addr_mode;
  logic       seg_remap;
  logic       com_remap;
  logic       cmd_err;

  modport master (
    output cs, sclk, sdo, dc, res,
    input  byte_valid, byte_data, byte_is_data, disp_on, charge_pump, contrast,
           precharge, com_cfg, addr_mode, seg_remap, com_remap, cmd_err
  );

  modport slave (
    input  cs, sclk, sdo, dc, res,
    output byte_valid, byte_data, byte_is_data, disp_on, charge_pump, contrast,
           precharge, com_cfg, addr_mode, seg_remap, com_remap, cmd_err
  );
endinterface

`default_nettype wire

// File: rtl/oled_cmd_rx_spi_rx_shift.sv
//------------------------------------------------------------------------------
// spi_rx_shift : input sync/registering, sclk edge detect, bit counter, shifter
// OLED_CMD_RX_SYNC_EN adds two-flop synchronisers ahead of the input register.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_rx_shift (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       sdo,
  input  logic       dc,
  input  logic       res,
  output logic       strobe,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       res_ok
);

  // Packed as {res, cs, sclk, sdo, dc}; res reads as asserted until seen high
  localparam logic [4:0] IN_IDLE = 5'b01100;

  logic [4:0] in_raw;
  logic [4:0] in_s;
  logic [4:0] in_q;
  logic       sclk_prev;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       rise;

  assign in_raw = {res, cs, sclk, sdo, dc};

`ifdef OLED_CMD_RX_SYNC_EN
  logic [4:0] meta;
  logic [4:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= IN_IDLE;
      sync <= IN_IDLE;
    end else begin
      meta <= in_raw;
      sync <= meta;
    end
  end

  assign in_s = sync;
`else
  assign in_s = in_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q      <= IN_IDLE;
      sclk_prev <= 1'b1;
      bit_cnt   <= 3'd0;
      shift     <= 7'd0;
    end else begin
      in_q      <= in_s;
      sclk_prev <= in_q[2];
      if (!in_q[4] || in_q[3]) begin
        bit_cnt <= 3'd0;
      end else if (rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift   <= {shift[5:0], in_q[1]};
      end
    end
  end

  assign rise    = in_q[2] & ~sclk_prev & ~in_q[3] & in_q[4];
  assign strobe  = rise && (bit_cnt == 3'd7);
  assign rx_byte = {shift, in_q[1]};
  assign rx_dc   = in_q[0];
  assign res_ok  = in_q[4];

endmodule

`default_nettype wire

// File: rtl/oled_cmd_rx.sv
//------------------------------------------------------------------------------
// oled_cmd_rx : SPI receiver and SSD1306-style command decoder / shadow registers
// Build option OLED_CMD_RX_SYNC_EN selects synchronised inputs. Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module oled_cmd_rx
  import oled_cmd_rx_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  oled_cmd_rx_if.slave  bus
);

  logic       strobe;
  logic [7:0] rx_byte;
  logic       rx_dc;
  logic       res_ok;

  spi_rx_shift u_shift (
    .clk     (clk),
    .rst     (rst),
    .cs      (bus.cs),
    .sclk    (bus.sclk),
    .sdo     (bus.sdo),
    .dc      (bus.dc),
    .res     (bus.res),
    .strobe  (strobe),
    .rx_byte (rx_byte),
    .rx_dc   (rx_dc),
    .res_ok  (res_ok)
  );

  rx_state_t  state, state_n;
  logic [7:0] op, op_n;
  logic       byte_valid, byte_valid_n;
  logic [7:0] byte_data, byte_data_n;
  logic       byte_is_data, byte_is_data_n;
  logic       disp_on, disp_on_n;
  logic       charge_pump, charge_pump_n;
  logic [7:0] contrast, contrast_n;
  logic [7:0] precharge, precharge_n;
  logic [7:0] com_cfg, com_cfg_n;
  logic [1:0] addr_mode, addr_mode_n;
  logic       seg_remap, seg_remap_n;
  logic       com_remap, com_remap_n;
  logic       cmd_err, cmd_err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RxIdle;
      op           <= 8'h00;
      byte_valid   <= 1'b0;
      byte_data    <= 8'h00;
      byte_is_data <= 1'b0;
      disp_on      <= 1'b0;
      charge_pump  <= 1'b0;
      contrast     <= RST_CONTRAST;
      precharge    <= RST_PRECHARGE;
      com_cfg      <= RST_COM_CFG;
      addr_mode    <= RST_ADDR_MODE;
      seg_remap    <= 1'b0;
      com_remap    <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      state        <= state_n;
      op           <= op_n;
      byte_valid   <= byte_valid_n;
      byte_data    <= byte_data_n;
      byte_is_data <= byte_is_data_n;
      disp_on      <= disp_on_n;
      charge_pump  <= charge_pump_n;
      contrast     <= contrast_n;
      precharge    <= precharge_n;
      com_cfg      <= com_cfg_n;
      addr_mode    <= addr_mode_n;
      seg_remap    <= seg_remap_n;
      com_remap    <= com_remap_n;
      cmd_err      <= cmd_err_n;
    end
  end

  always_comb begin
    state_n        = state;
    op_n           = op;
    byte_valid_n   = 1'b0;
    byte_data_n    = byte_data;
    byte_is_data_n = byte_is_data;
    disp_on_n      = disp_on;
    charge_pump_n  = charge_pump;
    contrast_n     = contrast;
    precharge_n    = precharge;
    com_cfg_n      = com_cfg;
    addr_mode_n    = addr_mode;
    seg_remap_n    = seg_remap;
    com_remap_n    = com_remap;
    cmd_err_n      = 1'b0;

    // Display reset line held low acts as a level-sensitive clear of everything
    if (!res_ok) begin
      state_n        = RxIdle;
      op_n           = 8'h00;
      byte_data_n    = 8'h00;
      byte_is_data_n = 1'b0;
      disp_on_n      = 1'b0;
      charge_pump_n  = 1'b0;
      contrast_n     = RST_CONTRAST;
      precharge_n    = RST_PRECHARGE;
      com_cfg_n      = RST_COM_CFG;
      addr_mode_n    = RST_ADDR_MODE;
      seg_remap_n    = 1'b0;
      com_remap_n    = 1'b0;
    end else if (strobe) begin
      byte_valid_n   = 1'b1;
      byte_data_n    = rx_byte;
      byte_is_data_n = rx_dc;
      case (state)
        RxIdle: begin
          if (!rx_dc) begin
            if (takes_param(rx_byte)) begin
              op_n    = rx_byte;
              state_n = RxParam;
            end else begin
              case (rx_byte)
                CMD_DISP_OFF:  disp_on_n   = 1'b0;
                CMD_DISP_ON:   disp_on_n   = 1'b1;
                CMD_SEG_NORM:  seg_remap_n = 1'b0;
                CMD_SEG_REMAP: seg_remap_n = 1'b1;
                CMD_COM_NORM:  com_remap_n = 1'b0;
                CMD_COM_REMAP: com_remap_n = 1'b1;
                default:       cmd_err_n   = 1'b1;
              endcase
            end
          end
        end
        RxParam: begin
          state_n = RxIdle;
          op_n    = 8'h00;
          if (rx_dc) begin
            cmd_err_n = 1'b1;
          end else begin
            case (op)
              CMD_CONTRAST:    contrast_n    = rx_byte;
              CMD_CHARGE_PUMP: charge_pump_n = rx_byte[2];
              CMD_PRECHARGE:   precharge_n   = rx_byte;
              CMD_COM_CFG:     com_cfg_n     = rx_byte;
              CMD_ADDR_MODE:   addr_mode_n   = rx_byte[1:0];
              default:         cmd_err_n     = 1'b1;
            endcase
          end
        end
        default: state_n = RxIdle;
      endcase
    end
  end

  assign bus.byte_valid   = byte_valid;
  assign bus.byte_data    = byte_data;
  assign bus.byte_is_data = byte_is_data;
  assign bus.disp_on      = disp_on;
  assign bus.charge_pump  = charge_pump;
  assign bus.contrast     = contrast;
  assign bus.precharge    = precharge;
  assign bus.com_cfg      = com_cfg;
  assign bus.addr_mode    = addr_mode;
  assign bus.seg_remap    = seg_remap;
  assign bus.com_remap    = com_remap;
  assign bus.cmd_err      = cmd_err;

endmodule

`default_nettype wire
